// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
package instr_fetch_stage_pkg;

  // First byte address of the text segment; also the reset PC.
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  // All-zero word is treated as a NOP by decode.
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // True when addr is word aligned and inside [base, base + 4*words).
  // The upper bound is formed in 33 bits so a window ending at 2^32 cannot wrap.
  function automatic logic fetch_ok(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(words) << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_register.sv
// Program counter flop and next-PC selection.
module instr_fetch_stage_pc_register
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(TEXT_BASE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,       // low in BOOT, HALT or on a fault edge
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  flush,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] pc
);

  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_seq;

  assign pc_seq = pc_q + DATA_WIDTH'(4);
  assign pc     = pc_q;

  // Next-PC mux: redirect beats flush, flush beats stall, otherwise sequential.
  always_comb begin
    pc_d = pc_q;
    if (enable) begin
      if (redirect) begin
        pc_d = redirect_pc;
      end else if (flush) begin
        pc_d = pc_seq;
      end else if (!stall) begin
        pc_d = pc_seq;
      end
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, fetch counter and boot/run/halt control.
module instr_fetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = DATA_WIDTH'(instr_fetch_stage_pkg::TEXT_BASE),
  parameter int unsigned           TEXT_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [DATA_WIDTH-1:0] ifid_pc4,
  output logic                  ifid_valid,
  output logic                  fetch_fault,
  output logic [31:0]           fetch_count
);

  import instr_fetch_stage_pkg::*;

  fetch_state_e          state_d, state_q;
  logic [DATA_WIDTH-1:0] instr_d, instr_q;
  logic [DATA_WIDTH-1:0] pc4_d, pc4_q;
  logic                  valid_d, valid_q;
  logic                  fault_d, fault_q;
  logic [31:0]           count_d, count_q;
  logic                  fault_now;
  logic                  pc_enable;

  assign fault_now = (state_q == RUN) && !fetch_ok(32'(pc), 32'(TEXT_BASE), TEXT_WORDS);
  assign pc_enable = (state_q == RUN) && !fault_now;

  instr_fetch_stage_pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (TEXT_BASE)
  ) u_pc_register (
    .clk         (clk),
    .reset       (reset),
    .enable      (pc_enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .stall       (stall),
    .pc          (pc)
  );

  assign rom_addr    = pc;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

  // Next state for the FSM, IF/ID register, fault flag and counter.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (fault_now) begin
          // rom_q is not trusted at a bad address, so nothing is captured.
          state_d = HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
          instr_d = DATA_WIDTH'(NOP);
        end else if (redirect || flush) begin
          valid_d = 1'b0;
          instr_d = DATA_WIDTH'(NOP);
        end else if (!stall) begin
          instr_d = rom_q;
          pc4_d   = pc + DATA_WIDTH'(4);
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
        end
      end
      HALT: begin
        valid_d = 1'b0;
        instr_d = DATA_WIDTH'(NOP);
      end
      default: begin
        state_d = HALT;
        valid_d = 1'b0;
        instr_d = DATA_WIDTH'(NOP);
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      instr_q <= DATA_WIDTH'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: per-cycle vector table with a scoreboard queue.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] rom_addr;
  logic [31:0] rom_q;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int tests  = 0;
  int failed = 0;
  int row    = -1;

  typedef struct {
    logic        areset;  // pulse an asynchronous reset (mid-cycle) before this row
    logic        stall;
    logic        redirect;
    logic        flush;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_count;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  instr_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pc          (pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  // ROM model: word i holds 32'h2000_0000 + i.
  assign rom_q = 32'h2000_0000 + ((rom_addr - 32'h0040_0000) >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic ar, input logic st, input logic rd, input logic fl,
                     input logic [31:0] rpc, input logic [31:0] epc, input logic ev,
                     input logic [31:0] ei, input logic [31:0] ep4, input logic [31:0] ec,
                     input logic ef);
    vec_t v;
    v.areset = ar; v.stall = st; v.redirect = rd; v.flush = fl; v.rpc = rpc;
    v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep4; v.e_count = ec;
    v.e_fault = ef;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pc"}, pc, 32'h0040_0000);
    chk({tag, " rom_addr"}, rom_addr, 32'h0040_0000);
    chk({tag, " ifid_valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, " ifid_instr"}, ifid_instr, 32'd0);
    chk({tag, " ifid_pc4"}, ifid_pc4, 32'd0);
    chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, " fetch_count"}, fetch_count, 32'd0);
  endtask

  // Assert reset between clock edges, with stall and redirect active, and check
  // that state clears before any further edge.
  task automatic async_reset();
    #2;
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0080;
    reset       = 1'b1;
    #1;
    chk_reset_state("async reset");
    @(negedge clk);
    reset    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  initial begin
    vec_t exp;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; flush = 1'b0; redirect_pc = '0;

    // Free run, stall, flush, redirect combos, then a misaligned redirect into HALT.
    add(0, 0, 0, 0, 32'h0,         32'h0040_0000, 0, 32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0004, 1, 32'h2000_0000, 32'h0040_0004, 1, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 2, 0);
    add(0, 1, 0, 0, 32'h0,         32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 2, 0);
    add(0, 1, 0, 0, 32'h0,         32'h0040_0008, 1, 32'h2000_0001, 32'h0040_0008, 2, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_000C, 1, 32'h2000_0002, 32'h0040_000C, 3, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0010, 1, 32'h2000_0003, 32'h0040_0010, 4, 0);
    add(0, 0, 0, 1, 32'h0,         32'h0040_0014, 0, 32'h0,         32'h0040_0010, 4, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0018, 1, 32'h2000_0005, 32'h0040_0018, 5, 0);
    add(0, 1, 1, 0, 32'h0040_0020, 32'h0040_0020, 0, 32'h0,         32'h0040_0018, 5, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0024, 1, 32'h2000_0008, 32'h0040_0024, 6, 0);
    add(0, 0, 1, 1, 32'h0040_0040, 32'h0040_0040, 0, 32'h0,         32'h0040_0024, 6, 0);
    add(0, 1, 0, 1, 32'h0,         32'h0040_0044, 0, 32'h0,         32'h0040_0024, 6, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0048, 1, 32'h2000_0011, 32'h0040_0048, 7, 0);
    add(0, 0, 1, 0, 32'h0040_0102, 32'h0040_0102, 0, 32'h0,         32'h0040_0048, 7, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0102, 0, 32'h0,         32'h0040_0048, 7, 1);
    add(0, 0, 1, 0, 32'h0040_0000, 32'h0040_0102, 0, 32'h0,         32'h0040_0048, 7, 1);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0102, 0, 32'h0,         32'h0040_0048, 7, 1);
    // Sequential fetch off the top of the window.
    add(1, 0, 0, 0, 32'h0,         32'h0040_0000, 0, 32'h0,         32'h0,         0, 0);
    add(0, 0, 1, 0, 32'h0040_00F8, 32'h0040_00F8, 0, 32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_00FC, 1, 32'h2000_003E, 32'h0040_00FC, 1, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0100, 1, 32'h2000_003F, 32'h0040_0100, 2, 0);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0100, 0, 32'h0,         32'h0040_0100, 2, 1);
    add(0, 0, 0, 0, 32'h0,         32'h0040_0100, 0, 32'h0,         32'h0040_0100, 2, 1);
    // Redirect just below the window.
    add(1, 0, 0, 0, 32'h0,         32'h0040_0000, 0, 32'h0,         32'h0,         0, 0);
    add(0, 0, 1, 0, 32'h003F_FFFC, 32'h003F_FFFC, 0, 32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,         32'h003F_FFFC, 0, 32'h0,         32'h0,         0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      if (vecs[i].areset) async_reset();
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      flush       = vecs[i].flush;
      redirect_pc = vecs[i].rpc;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      chk("pc", pc, exp.e_pc);
      chk("rom_addr", rom_addr, exp.e_pc);
      chk("ifid_valid", 32'(ifid_valid), 32'(exp.e_valid));
      chk("ifid_instr", ifid_instr, exp.e_instr);
      chk("ifid_pc4", ifid_pc4, exp.e_pc4);
      chk("fetch_count", fetch_count, exp.e_count);
      chk("fetch_fault", 32'(fetch_fault), 32'(exp.e_fault));
    end

    // Clear a HALT with an asynchronous reset.
    row = vecs.size();
    async_reset();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Upstream neighbour of the instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the ROM's combinational instruction word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, flush and illegal-fetch detection; feeds the decode stage.

Parameters:
- DATA_WIDTH, 32, instruction and PC width.
- TEXT_BASE, 32'h0040_0000, reset PC; first byte address of the text segment.
- TEXT_WORDS, 64, number of instruction words in the ROM window.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- redirect  in  1  branch taken or jump this cycle.
- redirect_pc  in  32  target byte address for redirect.
- flush  in  1  squash IF/ID without a new target.
- rom_addr  out  32  byte address to ROM; equals pc.
- rom_q  in  32  instruction word from ROM, combinational on rom_addr.
- pc  out  32  current fetch PC.
- ifid_instr  out  32  registered instruction.
- ifid_pc4  out  32  registered PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky; set on misaligned or out-of-window PC.
- fetch_count  out  32  number of instructions delivered to IF/ID.

Behaviour:
- Reset (async):
  - pc=TEXT_BASE, ifid_instr=0 (NOP), ifid_pc4=0, ifid_valid=0, fetch_fault=0, fetch_count=0.
  - State=BOOT.
- States: BOOT -> RUN -> HALT.
  - BOOT: lasts one cycle after reset deassert. IF/ID stays invalid, PC held. Next state RUN.
  - RUN: normal fetch.
  - HALT: entered on fault. PC frozen, ifid_valid=0, ifid_instr=0. Exit only via reset.
- Fault check, combinational on pc in RUN:
  - Condition: pc[1:0]!=0, or pc<TEXT_BASE, or pc>=TEXT_BASE+4*TEXT_WORDS.
  - At the next edge: fetch_fault<=1, state<=HALT, ifid_valid<=0. rom_q is not captured.
- Per-edge priority in RUN, highest first:
  1. reset.
  2. fault.
  3. redirect: pc<=redirect_pc; ifid_valid<=0, ifid_instr<=0. Wrong-path squash; overrides stall.
  4. flush: pc<=pc+4; ifid_valid<=0, ifid_instr<=0.
  5. stall: pc, ifid_* and fetch_count all hold.
  6. Normal: ifid_instr<=rom_q, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
- Latency: one cycle from pc to ifid_instr.
- Simultaneous events:
  - redirect+flush acts as redirect.
  - redirect+stall acts as redirect.
  - flush+stall acts as flush.
- Arithmetic:
  - pc+4 is 32-bit modulo; wrap to 0 faults as out-of-window.
  - fetch_count wraps modulo 2^32.
- rom_addr is pure combinational: rom_addr=pc.
- A redirect_pc that is out of window is accepted. The fault is raised on the following edge.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, regardless of clock.

Decomposition:
- Shared package:
  - TEXT_BASE.
  - NOP encoding 32'h0000_0000.
  - Fetch-state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2).
  - Fault-check function (aligned and in-window).
- One natural sub-module: pc_register.
  - PC flop with async reset to TEXT_BASE.
  - Next-PC mux (redirect/flush/stall/seq).
- IF/ID register, counter and FSM stay in the top.

Test Plan:
- Reset then 3 free-run cycles, ROM word i = 32'h2000_0000+i:
  - After BOOT, ifid_instr = 32'h2000_0000, then 32'h2000_0001.
  - ifid_pc4 = 32'h0040_0004, then 32'h0040_0008.
  - fetch_count = 2.
- stall=1 for 2 cycles at pc=32'h0040_0008:
  - pc, ifid_instr and fetch_count unchanged.
  - On release, next ifid_pc4 = 32'h0040_000C.
- redirect=1 with redirect_pc=32'h0040_0020 and stall=1 together:
  - Next edge: pc=32'h0040_0020, ifid_valid=0.
  - Following edge: ifid_instr = ROM word 8.
- flush=1 at pc=32'h0040_0010:
  - ifid_valid=0, ifid_instr=0, pc=32'h0040_0014, fetch_count unchanged.
- redirect_pc=32'h0040_0102 (misaligned):
  - One edge later, fetch_fault=1 and state HALT.
  - Further redirects are ignored.
  - pc stays 32'h0040_0102 until reset.
- Sequential fetch to pc=32'h0040_0100 (TEXT_WORDS=64):
  - fetch_fault=1 and ifid_valid=0.
  - Async reset mid-cycle restores pc=32'h0040_0000 and fault=0 without waiting for a clock edge.
